pin_id_multilane_tx: RTL and testbench

//  Pin-identification transmitter for board bring-up and pinout reverse mapping.
//  - Every FPGA pin under test emits a UART-style frame that carries its own ID.
//  - A probe or logic analyser on any pad recovers which package pin it is.
//  - Up to N_LANES pins transmit concurrently, one slot at a time, to shorten a full sweep.
//  - Supports one-shot and continuous sweep modes and a runtime baud divider.
//  - Frame words come from an external synchronous ROM (id table), one word per pin.
//  - Sits directly behind the top-level output pads. All non-transmitting pins idle high.

---
 rtl/pin_id_pkg.sv | 19 +
 rtl/pin_id_baud_gen.sv | 36 +++
 rtl/pin_id_multilane_tx.sv | 196 +++++++++++++++++++
 tb/tb_pin_id_multilane_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pin_id_pkg.sv
// Shared types and constants for the multilane pin-identification transmitter.
package pin_id_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } pin_id_state_e;

  localparam int DEF_FRAME_BITS = 46;
  localparam int DEF_GAP_BITS   = 8;

  // Number of slots needed to cover every pin, including a partial last slot.
  function automatic int slot_count(input int n_pins, input int n_lanes);
    return (n_pins + n_lanes - 1) / n_lanes;
  endfunction

endpackage

// File: rtl/pin_id_baud_gen.sv
// Baud tick generator: down-counter reloaded with div, tick while enabled and at zero.
module pin_id_baud_gen
  import pin_id_pkg::*;
#(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = div;
    end else if (enable) begin
      cnt_d = tick ? div : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pin_id_multilane_tx.sv
// Pin-ID transmitter: each pin under test serialises its own ROM word, N_LANES pins per slot.
//  state | meaning
//  IDLE  | pads idle high, waiting for start
//  FETCH | read N_LANES ROM words into the lane shift registers
//  SHIFT | serialise frames LSB first, one bit per baud tick
//  GAP   | pads idle high for GAP_BITS bit times, then next slot / stop / done
module pin_id_multilane_tx
  import pin_id_pkg::*;
#(
  parameter int N_PINS     = 512,
  parameter int N_LANES    = 4,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int GAP_BITS   = DEF_GAP_BITS,
  parameter int DIV_W      = 12,
  parameter int ADDR_W     = $clog2(N_PINS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  stop_req,
  input  logic [DIV_W-1:0]      baud_div,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [FRAME_BITS-1:0] rom_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     cur_slot,
  output logic [N_PINS-1:0]     pin_out
);

  localparam int NSLOTS    = slot_count(N_PINS, N_LANES);
  localparam int LAST_BASE = (NSLOTS - 1) * N_LANES;
  localparam int FC_W      = $clog2(N_LANES + 1);
  localparam int BC_MAX    = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
  localparam int BC_W      = $clog2(BC_MAX + 1);
  localparam int IW        = ADDR_W + 5;

  pin_id_state_e state_q, state_d;
  logic                  cont_q, cont_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [ADDR_W-1:0]     cur_slot_q, cur_slot_d;
  logic [FC_W-1:0]       fetch_cnt_q, fetch_cnt_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] lane_sr_q [N_LANES];
  logic [FRAME_BITS-1:0] lane_sr_d [N_LANES];
  logic [N_PINS-1:0]     pin_out_q, pin_out_d;
  logic                  done_q, done_d;

  logic baud_load, baud_en, baud_tick;
  logic last_slot;

  pin_id_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .load   (baud_load),
    .enable (baud_en),
    .div    (div_q),
    .tick   (baud_tick)
  );

  assign last_slot = (cur_slot_q >= ADDR_W'(LAST_BASE));

  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    div_d       = div_q;
    cur_slot_d  = cur_slot_q;
    fetch_cnt_d = fetch_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    lane_sr_d   = lane_sr_q;
    done_d      = 1'b0;
    baud_load   = 1'b0;
    baud_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          cont_d      = continuous;
          div_d       = baud_div;
          cur_slot_d  = '0;
          fetch_cnt_d = '0;
        end
      end

      FETCH: begin
        // ROM word for lane k arrives the cycle after its address was issued
        for (int k = 0; k < N_LANES; k++) begin
          if (fetch_cnt_q == FC_W'(k + 1)) begin
            lane_sr_d[k] = rom_data;
          end
        end
        if (fetch_cnt_q == FC_W'(N_LANES)) begin
          state_d     = SHIFT;
          fetch_cnt_d = '0;
          baud_load   = 1'b1;
          bit_cnt_d   = BC_W'(FRAME_BITS - 1);
        end else begin
          fetch_cnt_d = fetch_cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        baud_en = 1'b1;
        if (baud_tick) begin
          for (int k = 0; k < N_LANES; k++) begin
            lane_sr_d[k] = {1'b1, lane_sr_q[k][FRAME_BITS-1:1]};
          end
          if (bit_cnt_q == '0) begin
            state_d   = GAP;
            bit_cnt_d = BC_W'(GAP_BITS - 1);
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end

      GAP: begin
        baud_en = 1'b1;
        if (baud_tick) begin
          if (bit_cnt_q == '0) begin
            if (stop_req) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (!last_slot) begin
              state_d     = FETCH;
              fetch_cnt_d = '0;
              cur_slot_d  = cur_slot_q + ADDR_W'(N_LANES);
            end else if (cont_q) begin
              state_d     = FETCH;
              fetch_cnt_d = '0;
              cur_slot_d  = '0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Lanes past the last physical pin are fetched but never decoded onto a pad
  always_comb begin
    logic [IW-1:0] idx;
    pin_out_d = '1;
    idx       = '0;
    if (state_q == SHIFT) begin
      for (int k = 0; k < N_LANES; k++) begin
        idx = IW'(cur_slot_q) + IW'(k);
        if (idx < IW'(N_PINS)) begin
          pin_out_d[idx[ADDR_W-1:0]] = lane_sr_q[k][0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cont_q      <= 1'b0;
      div_q       <= '0;
      cur_slot_q  <= '0;
      fetch_cnt_q <= '0;
      bit_cnt_q   <= '0;
      pin_out_q   <= '1;
      done_q      <= 1'b0;
      for (int k = 0; k < N_LANES; k++) begin
        lane_sr_q[k] <= '1;
      end
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      div_q       <= div_d;
      cur_slot_q  <= cur_slot_d;
      fetch_cnt_q <= fetch_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      pin_out_q   <= pin_out_d;
      done_q      <= done_d;
      lane_sr_q   <= lane_sr_d;
    end
  end

  assign rom_addr = cur_slot_q + ADDR_W'(fetch_cnt_q);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign cur_slot = cur_slot_q;
  assign pin_out  = pin_out_q;

endmodule

// File: tb/tb_pin_id_multilane_tx.sv
// Bench for pin_id_multilane_tx: an 8-pin and a 6-pin instance checked cycle by cycle against a timeline model.
module tb_pin_id_multilane_tx;

  localparam int NL = 4;
  localparam int FB = 46;
  localparam int GB = 8;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start8, cont8, stop8, busy8, done8;
  logic [DW-1:0] div8;
  logic [2:0]    addr8, slot8;
  logic [FB-1:0] data8;
  logic [7:0]    pin8;

  logic          start6, cont6, stop6, busy6, done6;
  logic [DW-1:0] div6;
  logic [2:0]    addr6, slot6;
  logic [FB-1:0] data6;
  logic [5:0]    pin6;

  logic [FB-1:0] rom8 [8];
  logic [FB-1:0] rom6 [8];

  int tests = 0;
  int fails = 0;

  pin_id_multilane_tx #(
    .N_PINS(8), .N_LANES(NL), .FRAME_BITS(FB), .GAP_BITS(GB), .DIV_W(DW)
  ) dut8 (
    .clk(clk), .rst(rst), .start(start8), .continuous(cont8), .stop_req(stop8),
    .baud_div(div8), .rom_addr(addr8), .rom_data(data8), .busy(busy8),
    .done(done8), .cur_slot(slot8), .pin_out(pin8)
  );

  pin_id_multilane_tx #(
    .N_PINS(6), .N_LANES(NL), .FRAME_BITS(FB), .GAP_BITS(GB), .DIV_W(DW)
  ) dut6 (
    .clk(clk), .rst(rst), .start(start6), .continuous(cont6), .stop_req(stop6),
    .baud_div(div6), .rom_addr(addr6), .rom_data(data6), .busy(busy6),
    .done(done6), .cur_slot(slot6), .pin_out(pin6)
  );

  // synchronous ROMs: data one clock after address
  always @(posedge clk) begin
    data8 <= rom8[addr8];
    data6 <= rom6[addr6];
  end

  typedef struct {
    int sel6;       // 1 = drive the 6-pin instance
    int bdiv;
    int cont;
    int stop_t;     // -2 none, -1 together with start, else cycle index
    int restart;    // re-pulse start and change baud_div mid-sweep
    int rst_t;      // -1 none, else cycle index of async reset
    int exp_slots;  // expected slots transmitted before IDLE
  } vec_t;

  task automatic check(input string name, input int t, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, t, act, exp);
    end
  endtask

  task automatic drive(input int sel6, input logic st, input logic co, input logic sp,
                       input logic [DW-1:0] dv);
    if (sel6 != 0) begin
      start6 = st; cont6 = co; stop6 = sp; div6 = dv;
    end else begin
      start8 = st; cont8 = co; stop8 = sp; div8 = dv;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int T, P, np, nslots, end_t, tend, s, slot, r, rr;
    logic [FB-1:0] words [8];
    logic [7:0]    ep, ap;
    logic          eb, ed, ab, ad, st, sp;
    logic [2:0]    ecs, acs;
    logic [DW-1:0] dv;
    T      = v.bdiv + 1;
    P      = NL + 1 + (FB + GB) * T;
    np     = (v.sel6 != 0) ? 6 : 8;
    nslots = (np + NL - 1) / NL;
    end_t  = v.exp_slots * P;
    tend   = (v.rst_t >= 0) ? v.rst_t : end_t + 6;
    for (int i = 0; i < 8; i++) words[i] = (v.sel6 != 0) ? rom6[i] : rom8[i];
    dv = DW'(v.bdiv);
    st = 1'b1;
    sp = (v.stop_t == -1);
    @(negedge clk);
    drive(v.sel6, st, 1'(v.cont), sp, dv);
    for (int t = 0; t <= tend; t++) begin
      @(negedge clk);
      if (t == 0) st = 1'b0;
      ep = '1; eb = 1'b0; ed = 1'b0; ecs = '0;
      if (t < end_t) begin
        s    = t / P;
        slot = s % nslots;
        r    = t - s * P;
        eb   = 1'b1;
        ecs  = 3'(slot * NL);
        for (int p = 0; p < 8; p++) begin
          if (p >= slot * NL && p < slot * NL + NL && p < np) begin
            rr = r - (NL + 2);
            if (rr >= 0 && rr < FB * T) ep[p] = words[p][rr / T];
          end
        end
      end else if (t == end_t) begin
        ed = 1'b1;
      end
      ap  = (v.sel6 != 0) ? {2'b11, pin6} : pin8;
      ab  = (v.sel6 != 0) ? busy6 : busy8;
      ad  = (v.sel6 != 0) ? done6 : done8;
      acs = (v.sel6 != 0) ? slot6 : slot8;
      check(name, t, {19'd0, ap, ab, ad, (eb ? acs : 3'd0)}, {19'd0, ep, eb, ed, ecs});
      if (v.restart != 0 && t == 40)  st = 1'b1;
      if (v.restart != 0 && t == 41)  st = 1'b0;
      if (v.restart != 0 && t == 100) dv = DW'(v.bdiv + 5);
      if (t == v.stop_t) sp = 1'b1;
      if (t == end_t)    sp = 1'b0;
      drive(v.sel6, st, 1'(v.cont), sp, dv);
      if (t == v.rst_t) begin
        rst = 1'b1;
        #1;
        ap  = (v.sel6 != 0) ? {2'b11, pin6} : pin8;
        ab  = (v.sel6 != 0) ? busy6 : busy8;
        acs = (v.sel6 != 0) ? slot6 : slot8;
        check("async_reset", t, {20'd0, ap, ab, acs}, {20'd0, 8'hFF, 1'b0, 3'd0});
        check("async_reset_addr", t, {29'd0, ((v.sel6 != 0) ? addr6 : addr8)}, 32'd0);
        #1;
        rst = 1'b0;
      end
    end
    drive(v.sel6, 1'b0, 1'b0, 1'b0, '0);
  endtask

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   T, P, np, nslots;
    rst = 1'b1;
    start8 = 0; cont8 = 0; stop8 = 0; div8 = '0;
    start6 = 0; cont6 = 0; stop6 = 0; div6 = '0;
    for (int p = 0; p < 8; p++) begin
      rom8[p] = FB'(p) | (FB'(8'h2A) << 8);
      rom6[p] = (p < 6) ? (FB'(p) | (FB'(8'h2A) << 8)) : '0;
    end

    //          sel6 bdiv cont stop_t restart rst_t exp_slots
    vecs[0] = '{0,   3,   0,   -2,    0,      -1,   2};  // one-shot, 4 clk/bit
    vecs[1] = '{1,   3,   0,   -2,    0,      -1,   2};  // partial last slot
    vecs[2] = '{0,   2,   1,   60,    0,      -1,   1};  // stop mid-SHIFT slot 0
    vecs[3] = '{0,   1,   0,   -2,    0,      47,   2};  // async reset at bit 20
    vecs[4] = '{0,   0,   0,   -2,    0,      -1,   2};  // 1 clk per bit
    vecs[5] = '{0,   3,   0,   -2,    1,      -1,   2};  // start/baud changes while busy
    vecs[6] = '{0,   0,   1,   -1,    0,      -1,   1};  // start and stop together
    vecs[7] = '{1,   0,   1,   130,   0,      -1,   3};  // continuous wrap then stop

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pins8", 0, {24'd0, pin8}, 32'h0000_00FF);
    check("reset_pins6", 0, {26'd0, pin6}, 32'h0000_003F);
    check("reset_ctl8", 0, {24'd0, busy8, done8, addr8, slot8}, 32'd0);
    check("reset_ctl6", 0, {24'd0, busy6, done6, addr6, slot6}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_pins8", 0, {23'd0, busy8, pin8}, 32'h0000_00FF);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    for (int n = 0; n < 6; n++) begin
      for (int p = 0; p < 8; p++) begin
        rom8[p] = FB'({$urandom(), $urandom()});
        rom6[p] = FB'({$urandom(), $urandom()});
      end
      rv.sel6    = int'($urandom_range(0, 1));
      rv.bdiv    = int'($urandom_range(0, 2));
      rv.cont    = int'($urandom_range(0, 1));
      rv.restart = int'($urandom_range(0, 1));
      rv.rst_t   = -1;
      T      = rv.bdiv + 1;
      P      = NL + 1 + (FB + GB) * T;
      np     = (rv.sel6 != 0) ? 6 : 8;
      nslots = (np + NL - 1) / NL;
      if (rv.cont != 0) begin
        rv.stop_t    = int'($urandom_range(0, 3 * P - 1));
        rv.exp_slots = rv.stop_t / P + 1;
      end else if ($urandom_range(0, 1) == 0) begin
        rv.stop_t    = -2;
        rv.exp_slots = nslots;
      end else begin
        rv.stop_t    = int'($urandom_range(0, nslots * P - 1));
        rv.exp_slots = rv.stop_t / P + 1;
      end
      run_vec(rv, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
